// File: rtl/hack_exec_ctrl.sv
// Multi-cycle Hack CPU control shell: fetches and decodes instructions, drives the external ALU,
// owns the A/D/PC registers and reaches data memory through a req/ack handshake.
module hack_exec_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          ADDR_W   = 15
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [15:0]       pc,
   output logic [15:0]       alu_x,
   output logic [15:0]       alu_y,
   output logic [5:0]        alu_ctl,
   input  logic [15:0]       alu_out,
   input  logic              alu_zr,
   input  logic              alu_ng,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [15:0]       a_reg,
   output logic [15:0]       d_reg
);

   typedef enum logic [1:0] {S_FETCH, S_MEM_RD, S_EXEC, S_MEM_WR} state_t;

   state_t            state_q;
   logic [15:0]       pc_q, a_q, d_q, m_q, ir_q, mem_wdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_req_q, mem_we_q;
   logic              jump_d;
   logic [15:0]       pc_d;

   // Jump decision and next PC; jump is only meaningful for C-instructions (IR[15]=1).
   always_comb begin
      jump_d = ir_q[15] & ((ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr));
      if (jump_d) begin
         pc_d = a_q;
      end else begin
         pc_d = pc_q + 16'd1;
      end
   end

   // Control FSM with all architectural and memory-interface registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         a_q         <= 16'h0000;
         d_q         <= 16'h0000;
         m_q         <= 16'h0000;
         ir_q        <= 16'h0000;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 16'h0000;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (instr_valid) begin
                  ir_q <= instr;
                  if (instr[15] && instr[12]) begin
                     state_q    <= S_MEM_RD;
                     mem_req_q  <= 1'b1;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= a_q[ADDR_W-1:0];
                  end else begin
                     state_q <= S_EXEC;
                  end
               end
            end
            S_MEM_RD: begin
               if (mem_ack) begin
                  m_q       <= mem_rdata;
                  mem_req_q <= 1'b0;
                  state_q   <= S_EXEC;
               end
            end
            S_EXEC: begin
               pc_q <= pc_d;
               if (!ir_q[15]) begin
                  a_q     <= ir_q;
                  state_q <= S_FETCH;
               end else begin
                  if (ir_q[5]) a_q <= alu_out;
                  if (ir_q[4]) d_q <= alu_out;
                  // Store address uses A as it was before this instruction wrote it.
                  if (ir_q[3]) begin
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= a_q[ADDR_W-1:0];
                     mem_wdata_q <= alu_out;
                     state_q     <= S_MEM_WR;
                  end else begin
                     state_q <= S_FETCH;
                  end
               end
            end
            S_MEM_WR: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= S_FETCH;
               end
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign instr_ready = (state_q == S_FETCH);
   assign pc          = pc_q;
   assign alu_x       = d_q;
   assign alu_y       = ((state_q == S_EXEC) && ir_q[15] && ir_q[12]) ? m_q : a_q;
   assign alu_ctl     = ir_q[11:6];
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign a_reg       = a_q;
   assign d_reg       = d_q;

endmodule
